// File: rtl/axi_aw_w_scheduler_if.sv
// AW/W scheduler bus bundle: per-requester AW/W handshakes, merged initiator side and occupancy.
// The scheduler uses the slave modport; whoever drives the requesters and the initiator uses master.
interface axi_aw_w_scheduler_if #(
   parameter int N_TARG_PORT = 4,
   parameter int FIFO_DEPTH  = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [N_TARG_PORT-1:0] awvalid_i;
   logic [N_TARG_PORT-1:0] awready_o;
   logic                   awvalid_o;
   logic                   awready_i;
   logic [N_TARG_PORT-1:0] aw_sel_o;
   logic [N_TARG_PORT-1:0] wvalid_i;
   logic [N_TARG_PORT-1:0] wlast_i;
   logic [N_TARG_PORT-1:0] wready_o;
   logic                   wvalid_o;
   logic                   wlast_o;
   logic                   wready_i;
   logic [N_TARG_PORT-1:0] w_sel_o;
   logic [CNT_W-1:0]       outstanding_o;

   modport slave (
      input  awvalid_i, awready_i, wvalid_i, wlast_i, wready_i,
      output awready_o, awvalid_o, aw_sel_o, wready_o, wvalid_o, wlast_o, w_sel_o, outstanding_o
   );

   modport master (
      output awvalid_i, awready_i, wvalid_i, wlast_i, wready_i,
      input  awready_o, awvalid_o, aw_sel_o, wready_o, wvalid_o, wlast_o, w_sel_o, outstanding_o
   );
endinterface

// File: rtl/axi_aw_w_scheduler.sv
// Round-robin AW arbiter that records each granted requester in an order FIFO so that
// W bursts are forwarded strictly in AW grant order.
//
// state   | meaning
// ST_ARB  | grant comes straight from the round-robin arbiter this cycle
// ST_HOLD | AW offered but not accepted; grant frozen in grant_q until handshake
module axi_aw_w_scheduler #(
   parameter int N_TARG_PORT = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic clk,
   input  logic rst,
   axi_aw_w_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(N_TARG_PORT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {ST_ARB, ST_HOLD} state_e;

   state_e                 state_q, state_d;
   logic [N_TARG_PORT-1:0] grant_q, grant_d;
   logic [N_TARG_PORT-1:0] arb_gnt, gnt;
   logic                   arb_hit;
   logic [IDX_W:0]         cand;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d, gnt_idx;
   logic                   aw_vld, push, pop;

   logic [N_TARG_PORT-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   fifo_full, fifo_empty;
   logic [N_TARG_PORT-1:0] head;
   logic                   w_vld, w_last;

   assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (cnt_q == '0);

   // First requesting index at or after rr_ptr_q, wrapping modulo N_TARG_PORT.
   always_comb begin
      arb_gnt = '0;
      arb_hit = 1'b0;
      cand    = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(N_TARG_PORT)) begin
            cand = cand - (IDX_W+1)'(N_TARG_PORT);
         end
         if (!arb_hit && bus.awvalid_i[cand[IDX_W-1:0]]) begin
            arb_hit                   = 1'b1;
            arb_gnt[cand[IDX_W-1:0]] = 1'b1;
         end
      end
   end

   // rst gates the offer so outputs are quiet for the whole reset window.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gnt     = (state_q == ST_HOLD) ? grant_q : arb_gnt;
      aw_vld  = (|gnt) && !fifo_full && !rst;
      push    = aw_vld && bus.awready_i;
      case (state_q)
         ST_ARB: begin
            if (aw_vld && !bus.awready_i) begin
               state_d = ST_HOLD;
               grant_d = gnt;
            end
         end
         ST_HOLD: begin
            if (push) begin
               state_d = ST_ARB;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_ARB;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_TARG_PORT; i++) begin
         if (gnt[i]) gnt_idx = IDX_W'(i);
      end
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (gnt_idx == IDX_W'(N_TARG_PORT - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   assign bus.awvalid_o = aw_vld;
   assign bus.aw_sel_o  = aw_vld ? gnt : '0;
   assign bus.awready_o = push ? gnt : '0;

   assign head   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
   assign w_vld  = |(bus.wvalid_i & head);
   assign w_last = |(bus.wlast_i & head);
   assign pop    = w_vld && bus.wready_i && w_last;

   assign bus.wvalid_o      = w_vld;
   assign bus.wlast_o       = w_last;
   assign bus.wready_o      = bus.wready_i ? head : '0;
   assign bus.w_sel_o       = head;
   assign bus.outstanding_o = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_ARB;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read while cnt_q says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= gnt;
      end
   end
endmodule
